// File: rtl/lv1_issue.sv
// Level-1 trigger issue stage: accepts or vetoes early_lv1 requests, delays each accepted
// request by lv1_delay, emits a numbered one-cycle lv1_out, then holds off for deadtime.
// Optional cycle timestamp of each accept is built when LV1_ISSUE_TSTAMP_EN is defined.
module lv1_issue #(
  parameter int DLY_W  = 8,
  parameter int DEAD_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              early_lv1,
  input  logic              ena_lv1,
  input  logic              daq_busy,
  input  logic [DLY_W-1:0]  lv1_delay,
  input  logic [DEAD_W-1:0] deadtime,
  output logic              lv1_out,
  output logic [CNT_W-1:0]  trig_num,
  output logic              busy_out,
  output logic [CNT_W-1:0]  n_accept,
  output logic [CNT_W-1:0]  n_veto,
  output logic [CNT_W-1:0]  lv1_tstamp
);

  typedef enum logic [1:0] {IDLE, DELAY, ISSUE, DEAD} state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DLY_W-1:0]  DLY_ONE  = {{(DLY_W-1){1'b0}}, 1'b1};
  localparam logic [DEAD_W-1:0] DEAD_ONE = {{(DEAD_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [DLY_W-1:0]  dly_cnt;
  logic [DEAD_W-1:0] dead_cnt;
  logic              accept;

  // Once accepted, a trigger is committed; gate and busy are only looked at in IDLE.
  assign accept = (state == IDLE) && early_lv1 && ena_lv1 && !daq_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      dly_cnt  <= '0;
      dead_cnt <= '0;
      lv1_out  <= 1'b0;
      busy_out <= 1'b0;
      trig_num <= '0;
      n_accept <= '0;
      n_veto   <= '0;
    end else begin
      lv1_out <= 1'b0;

      if (accept) begin
        if (n_accept != CNT_MAX) n_accept <= n_accept + CNT_ONE;
      end else if (early_lv1) begin
        if (n_veto != CNT_MAX) n_veto <= n_veto + CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            dly_cnt  <= lv1_delay;
            busy_out <= 1'b1;
            if (lv1_delay == '0) begin
              state    <= ISSUE;
              lv1_out  <= 1'b1;
              trig_num <= trig_num + CNT_ONE;
            end else begin
              state <= DELAY;
            end
          end
        end
        DELAY: begin
          dly_cnt <= dly_cnt - DLY_ONE;
          if (dly_cnt == DLY_ONE) begin
            state    <= ISSUE;
            lv1_out  <= 1'b1;
            trig_num <= trig_num + CNT_ONE;
          end
        end
        ISSUE: begin
          dead_cnt <= deadtime;
          if (deadtime == '0) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end else begin
            state <= DEAD;
          end
        end
        DEAD: begin
          dead_cnt <= dead_cnt - DEAD_ONE;
          if (dead_cnt == DEAD_ONE) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef LV1_ISSUE_TSTAMP_EN
  logic [CNT_W-1:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ts_cnt     <= '0;
      lv1_tstamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + CNT_ONE;
      if (accept) lv1_tstamp <= ts_cnt;
    end
  end
`else
  assign lv1_tstamp = '0;
`endif

endmodule

// File: tb/tb_lv1_issue.sv
// Directed plus randomized bench for lv1_issue, checked each cycle against a
// time-based reference model (accept edge, issue edge, next-free edge).
module tb_lv1_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        early_lv1 = 1'b0;
  logic        ena_lv1 = 1'b1;
  logic        daq_busy = 1'b0;
  logic [7:0]  lv1_delay = '0;
  logic [7:0]  deadtime = '0;
  logic        lv1_out;
  logic [31:0] trig_num;
  logic        busy_out;
  logic [31:0] n_accept;
  logic [31:0] n_veto;
  logic [31:0] lv1_tstamp;

  lv1_issue dut (
    .clk(clk), .rst(rst), .early_lv1(early_lv1), .ena_lv1(ena_lv1),
    .daq_busy(daq_busy), .lv1_delay(lv1_delay), .deadtime(deadtime),
    .lv1_out(lv1_out), .trig_num(trig_num), .busy_out(busy_out),
    .n_accept(n_accept), .n_veto(n_veto), .lv1_tstamp(lv1_tstamp)
  );

  always #5 clk = ~clk;

  localparam longint NEVER = 64'h7fff_ffff_ffff_ffff;

  // Reference model: edges are numbered; the block is free to accept at edge x iff x >= free_edge.
  longint      edge_n = 0;
  longint      free_edge = 0;
  longint      issue_edge = 0;
  bit          has_issue = 0;
  bit          m_out = 0;
  logic [31:0] m_trig = '0, m_acc = '0, m_veto = '0, m_ts = '0, m_tstamp = '0;

  int          n_pass = 0, n_checks = 0, n_fail = 0;
  int          pulses = 0, busy_cnt = 0;
  longint      out_edge = -1, acc_edge = 0;
  logic [31:0] veto0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit idle;
    if (!rst) begin
      m_trig = '0; m_acc = '0; m_veto = '0; m_ts = '0; m_tstamp = '0;
      has_issue = 0; free_edge = 0; m_out = 0;
    end else begin
      idle = (edge_n >= free_edge);
      if (has_issue && edge_n == issue_edge + 1) begin
        free_edge = edge_n + longint'(deadtime) + 1;
        has_issue = 0;
      end
      m_out = 0;
      if (early_lv1) begin
        if (idle && ena_lv1 && !daq_busy) begin
          if (m_acc != 32'hffff_ffff) m_acc = m_acc + 1;
          has_issue  = 1;
          issue_edge = edge_n + longint'(lv1_delay);
          free_edge  = NEVER;
          m_tstamp   = m_ts;
        end else if (m_veto != 32'hffff_ffff) begin
          m_veto = m_veto + 1;
        end
      end
      if (has_issue && edge_n == issue_edge) begin
        m_out  = 1;
        m_trig = m_trig + 1;
      end
      m_ts = m_ts + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("lv1_out", {31'd0, lv1_out}, {31'd0, m_out});
    check("trig_num", trig_num, m_trig);
    check("busy_out", {31'd0, busy_out}, {31'd0, (edge_n + 1 < free_edge)});
    check("n_accept", n_accept, m_acc);
    check("n_veto", n_veto, m_veto);
`ifdef LV1_ISSUE_TSTAMP_EN
    check("lv1_tstamp", lv1_tstamp, m_tstamp);
`else
    check("lv1_tstamp", lv1_tstamp, 32'd0);
`endif
    if (lv1_out === 1'b1) begin
      pulses   = pulses + 1;
      out_edge = edge_n;
    end
    if (busy_out === 1'b1) busy_cnt = busy_cnt + 1;
    edge_n = edge_n + 1;
  endtask

  initial begin
    // Reset held with requests present: nothing counted
    rst = 1'b0; early_lv1 = 1'b1;
    repeat (3) tick();
    check("rst_n_veto", n_veto, 32'd0);
    check("rst_n_accept", n_accept, 32'd0);
    early_lv1 = 1'b0; rst = 1'b1;
    repeat (2) tick();

    // Single trigger, delay 5, deadtime 3
    lv1_delay = 8'd5; deadtime = 8'd3; ena_lv1 = 1'b1; daq_busy = 1'b0;
    pulses = 0; busy_cnt = 0; acc_edge = edge_n;
    early_lv1 = 1'b1; tick(); early_lv1 = 1'b0;
    repeat (12) tick();
    check("t2_pulses", pulses, 32'd1);
    check("t2_busy_cycles", busy_cnt, 32'd9);
    check("t2_latency", 32'(out_edge - acc_edge), 32'd5);
    check("t2_trig_num", trig_num, 32'd1);

    // Zero delay/deadtime, request held: accept/veto alternate
    lv1_delay = 8'd0; deadtime = 8'd0; pulses = 0; veto0 = m_veto;
    early_lv1 = 1'b1; repeat (10) tick(); early_lv1 = 1'b0;
    tick();
    check("t3_pulses", pulses, 32'd5);
    check("t3_vetoes", n_veto - veto0, 32'd5);

    // Gate closed or DAQ busy: all vetoed
    pulses = 0; veto0 = m_veto;
    for (int i = 0; i < 4; i++) begin
      ena_lv1 = i[0]; daq_busy = i[0];
      early_lv1 = 1'b1; tick(); early_lv1 = 1'b0; tick();
    end
    check("t4_pulses", pulses, 32'd0);
    check("t4_vetoes", n_veto - veto0, 32'd4);

    // Gate drops after accept: trigger still issues
    ena_lv1 = 1'b1; daq_busy = 1'b0; lv1_delay = 8'd5; pulses = 0;
    early_lv1 = 1'b1; tick(); early_lv1 = 1'b0;
    tick(); tick();
    ena_lv1 = 1'b0; daq_busy = 1'b1;
    repeat (6) tick();
    check("t4_late_gate", pulses, 32'd1);

    // Reset in the 3rd DELAY cycle aborts the pending trigger
    ena_lv1 = 1'b1; daq_busy = 1'b0; lv1_delay = 8'd6;
    tick();
    early_lv1 = 1'b1; tick(); early_lv1 = 1'b0;
    tick(); tick();
    rst = 1'b0; tick(); rst = 1'b1;
    pulses = 0;
    repeat (8) tick();
    check("t5_no_pulse", pulses, 32'd0);
    lv1_delay = 8'd1;
    early_lv1 = 1'b1; tick(); early_lv1 = 1'b0;
    repeat (4) tick();
    check("t5_trig_restart", trig_num, 32'd1);

    // Timestamp of an accept 20 cycles after reset
    rst = 1'b0; tick(); rst = 1'b1;
    repeat (20) tick();
    early_lv1 = 1'b1; tick(); early_lv1 = 1'b0;
    repeat (3) tick();
`ifdef LV1_ISSUE_TSTAMP_EN
    check("t6_tstamp", lv1_tstamp, 32'd20);
`else
    check("t6_tstamp", lv1_tstamp, 32'd0);
`endif

    // Randomized traffic, including mid-operation parameter changes and rare resets
    repeat (2000) begin
      early_lv1 = ($urandom_range(0, 9) < 4);
      ena_lv1   = ($urandom_range(0, 9) != 0);
      daq_busy  = ($urandom_range(0, 7) == 0);
      lv1_delay = 8'($urandom_range(0, 6));
      deadtime  = 8'($urandom_range(0, 4));
      rst       = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst = 1'b1; early_lv1 = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
